outpass_pipe_config: RTL

- Parametrised successor of the 4-bit fixed output-pass BEL: N output channels, each configured independently.
- Each channel runs as a combinational bypass or a 1..MAX_DEPTH-stage register pipeline. The channel's depth field in the frame config bits selects the mode.
- Adds a shared clock enable, a synchronous reset and a pipeline-primed status flag.
- Sits in the RAM_IO / IO tiles between the switch matrix and EXTERNAL fabric outputs.

---
 rtl/outpass_pipe_config.sv | 85 ++++++++
 1 files changed

// File: rtl/outpass_pipe_config.sv
// rtl/outpass_pipe_config.sv - per-channel bypass/pipelined output pass; optional inversion under OUTPASS_PIPE_INVERT_EN
module outpass_pipe_config #(
    parameter int WIDTH        = 8,
    parameter int MAX_DEPTH    = 3,
    parameter int NoConfigBits = 16
) (
    input  logic                    UserCLK,
    input  logic                    UserRST,
    input  logic                    CE,
    input  logic [WIDTH-1:0]        I,
    output logic [WIDTH-1:0]        O,
    output logic                    Primed,
    input  logic [NoConfigBits-1:0] ConfigBits
);

`ifdef OUTPASS_PIPE_INVERT_EN
    localparam int EXP_BITS = WIDTH * 3;
`else
    localparam int EXP_BITS = WIDTH * 2;
`endif

    // Fill counter is just wide enough to count up to MAX_DEPTH.
    localparam int             FW    = $clog2(MAX_DEPTH + 1);
    localparam logic [FW-1:0]  F_MAX = FW'(MAX_DEPTH);
    // Tap index width; a single-stage pipeline still needs a 1-bit index.
    localparam int             IW    = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam logic [1:0]     D_MAX = 2'(MAX_DEPTH);

    generate
        if (NoConfigBits != EXP_BITS) begin : g_bad_cfg_bits
            $error("outpass_pipe_config: NoConfigBits does not match channel count");
        end
        if (MAX_DEPTH < 1 || MAX_DEPTH > 3) begin : g_bad_depth
            $error("outpass_pipe_config: MAX_DEPTH must be 1..3");
        end
    endgenerate

    logic [FW-1:0] fill;

    // Fill counter: counts enabled edges since reset and sticks at MAX_DEPTH.
    always_ff @(posedge UserCLK) begin
        if (UserRST) begin
            fill <= '0;
        end else if (CE && fill != F_MAX) begin
            fill <= fill + FW'(1);
        end
    end

    // Counter is a register, so the compare gives a clean registered flag.
    assign Primed = (fill == F_MAX);

    genvar k;
    generate
        for (k = 0; k < WIDTH; k++) begin : g_ch
            logic [MAX_DEPTH-1:0] stage;
            logic [1:0]           depth;
            logic [1:0]           eff;
            logic                 tap;

            // Shift register always advances on CE; the depth field only picks the tap.
            always_ff @(posedge UserCLK) begin
                if (UserRST) begin
                    stage <= '0;
                end else if (CE) begin
                    stage[0] <= I[k];
                    for (int j = 1; j < MAX_DEPTH; j++) begin
                        stage[j] <= stage[j-1];
                    end
                end
            end

            assign depth = ConfigBits[2*k +: 2];
            // Oversized depth saturates silently rather than flagging an error.
            assign eff   = (depth > D_MAX) ? D_MAX : depth;
            assign tap   = (eff == 2'd0) ? I[k] : stage[IW'(eff - 2'd1)];

`ifdef OUTPASS_PIPE_INVERT_EN
            assign O[k] = tap ^ ConfigBits[2*WIDTH + k];
`else
            assign O[k] = tap;
`endif
        end
    endgenerate

endmodule
